ctr_rmw_engine: RTL

Read-modify-write counter engine placed directly upstream of the 2-read/1-write memory (mem_2r1w). It turns a stream of per-address increment requests into memory read (port 0) and write (port 2) traffic, and covers the memory's SRAM_DELAY read latency with an address-matched forwarding pipeline, so back-to-back updates to one address never lose a count. It also zero-initialises the memory after reset and serves a read-only query path on memory port 1.

---
 rtl/ctr_rmw_engine.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ctr_rmw_engine.sv
// ctr_rmw_engine
//   Read-modify-write counter engine in front of a 2-read/1-write memory.
//   Increment requests read the counter on port 0, add the delta
//   SRAM_DELAY cycles later (saturating) and write back on port 2.
//   A short history of recent write-backs covers the read latency, so
//   back-to-back updates to one address never lose a count. After reset
//   the engine zero-fills the memory before raising ready. Port 1 serves
//   read-only queries straight from memory.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ready                         init done, requests accepted
//   upd_vld/upd_adr/upd_delta     increment request
//   qry_vld/qry_adr               query request
//   qry_rvld/qry_dout             query response, SRAM_DELAY cycles later
//   sat_pulse                     write-back clipped at the counter maximum
//   mem_ready                     memory ready to accept init writes
//   mem_read_0/mem_rd_adr_0/mem_rd_dout_0      update read port
//   mem_read_1/mem_rd_adr_1/mem_rd_dout_1      query read port
//   mem_write_2/mem_wr_adr_2/mem_wr_din_2      write port
module ctr_rmw_engine #(
    parameter int NUMADDR    = 8,
    parameter int BITADDR    = 3,
    parameter int BITDATA    = 8,
    parameter int BITDELTA   = 4,
    parameter int SRAM_DELAY = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                upd_vld,
    input  logic [BITADDR-1:0]  upd_adr,
    input  logic [BITDELTA-1:0] upd_delta,
    input  logic                qry_vld,
    input  logic [BITADDR-1:0]  qry_adr,
    output logic                qry_rvld,
    output logic [BITDATA-1:0]  qry_dout,
    output logic                sat_pulse,
    input  logic                mem_ready,
    output logic                mem_read_0,
    output logic [BITADDR-1:0]  mem_rd_adr_0,
    input  logic [BITDATA-1:0]  mem_rd_dout_0,
    output logic                mem_read_1,
    output logic [BITADDR-1:0]  mem_rd_adr_1,
    input  logic [BITDATA-1:0]  mem_rd_dout_1,
    output logic                mem_write_2,
    output logic [BITADDR-1:0]  mem_wr_adr_2,
    output logic [BITDATA-1:0]  mem_wr_din_2
);

    typedef enum logic [1:0] {RESET, INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [BITADDR-1:0] init_adr_q, init_adr_d;
    logic               init_wr;
    logic               init_last;

    logic               upd_acc, qry_acc;

    // write-back stage (the accept cycle when SRAM_DELAY is 0)
    logic                wb_vld;
    logic [BITADDR-1:0]  wb_adr;
    logic [BITDELTA-1:0] wb_delta;
    logic [BITDATA-1:0]  base;
    logic [BITDATA:0]    sum;
    logic                wb_sat;
    logic [BITDATA-1:0]  wb_data;

    // ---------------------------------------------------------------
    // Init / run control. The first zero-write happens in the same
    // cycle RESET sees mem_ready, so ready rises NUMADDR cycles later.
    // ---------------------------------------------------------------
    assign init_last = (init_adr_q == BITADDR'(NUMADDR - 1));

    always_comb begin
        state_d    = state_q;
        init_adr_d = init_adr_q;
        init_wr    = 1'b0;
        case (state_q)
            RESET: begin
                if (mem_ready) begin
                    init_wr    = 1'b1;
                    init_adr_d = init_adr_q + BITADDR'(1);
                    state_d    = init_last ? RUN : INIT;
                end
            end
            INIT: begin
                init_wr    = 1'b1;
                init_adr_d = init_adr_q + BITADDR'(1);
                if (init_last) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET;
            init_adr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_adr_q <= init_adr_d;
        end
    end

    assign ready   = (state_q == RUN);
    assign upd_acc = ready & upd_vld & ~rst;
    assign qry_acc = ready & qry_vld & ~rst;

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    assign mem_read_0   = upd_acc;
    assign mem_rd_adr_0 = upd_adr;
    assign mem_read_1   = qry_acc;
    assign mem_rd_adr_1 = qry_adr;
    assign qry_dout     = mem_rd_dout_1;

    // ---------------------------------------------------------------
    // Saturating add; delta is zero-extended so the carry-out is the
    // overflow flag.
    // ---------------------------------------------------------------
    always_comb begin
        sum     = {1'b0, base} + {{(BITDATA + 1 - BITDELTA){1'b0}}, wb_delta};
        wb_sat  = sum[BITDATA];
        wb_data = wb_sat ? {BITDATA{1'b1}} : sum[BITDATA-1:0];
    end

    generate
        if (SRAM_DELAY == 0) begin : g_nodly
            // Read data is already current; no history needed.
            always_comb begin
                wb_vld   = upd_acc;
                wb_adr   = upd_adr;
                wb_delta = upd_delta;
                base     = mem_rd_dout_0;
            end
            assign qry_rvld = qry_acc;
        end else begin : g_pipe
            // index 1 is one cycle after accept, SRAM_DELAY is the write stage
            logic [SRAM_DELAY:1] pv_q, pv_d;
            logic [BITADDR-1:0]  pa_q [1:SRAM_DELAY];
            logic [BITADDR-1:0]  pa_d [1:SRAM_DELAY];
            logic [BITDELTA-1:0] pd_q [1:SRAM_DELAY];
            logic [BITDELTA-1:0] pd_d [1:SRAM_DELAY];
            // write-back history, index 1 = written last cycle
            logic [SRAM_DELAY:1] hv_q, hv_d;
            logic [BITADDR-1:0]  ha_q [1:SRAM_DELAY];
            logic [BITADDR-1:0]  ha_d [1:SRAM_DELAY];
            logic [BITDATA-1:0]  hd_q [1:SRAM_DELAY];
            logic [BITDATA-1:0]  hd_d [1:SRAM_DELAY];
            logic [SRAM_DELAY:1] qv_q, qv_d;

            always_comb begin
                pv_d = pv_q;
                pa_d = pa_q;
                pd_d = pd_q;
                hv_d = hv_q;
                ha_d = ha_q;
                hd_d = hd_q;
                qv_d = qv_q;
                pv_d[1] = upd_acc;
                pa_d[1] = upd_adr;
                pd_d[1] = upd_delta;
                hv_d[1] = wb_vld;
                ha_d[1] = wb_adr;
                hd_d[1] = wb_data;
                qv_d[1] = qry_acc;
                for (int k = 2; k <= SRAM_DELAY; k++) begin
                    pv_d[k] = pv_q[k-1];
                    pa_d[k] = pa_q[k-1];
                    pd_d[k] = pd_q[k-1];
                    hv_d[k] = hv_q[k-1];
                    ha_d[k] = ha_q[k-1];
                    hd_d[k] = hd_q[k-1];
                    qv_d[k] = qv_q[k-1];
                end
            end

            // The history spans exactly the writes issued since this
            // request read memory; scan oldest to newest so the newest
            // matching write-back wins.
            always_comb begin
                wb_vld   = pv_q[SRAM_DELAY];
                wb_adr   = pa_q[SRAM_DELAY];
                wb_delta = pd_q[SRAM_DELAY];
                base     = mem_rd_dout_0;
                for (int k = SRAM_DELAY; k >= 1; k--) begin
                    if (hv_q[k] && (ha_q[k] == wb_adr)) base = hd_q[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    hv_q <= '0;
                    qv_q <= '0;
                end else begin
                    pv_q <= pv_d;
                    hv_q <= hv_d;
                    qv_q <= qv_d;
                end
            end

            always_ff @(posedge clk) begin
                pa_q <= pa_d;
                pd_q <= pd_d;
                ha_q <= ha_d;
                hd_q <= hd_d;
            end

            assign qry_rvld = qv_q[SRAM_DELAY];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Write port: INIT and RUN never overlap, rst blocks everything.
    // ---------------------------------------------------------------
    logic run_wr;
    assign run_wr = ~rst & (state_q == RUN) & wb_vld;

    assign mem_write_2  = run_wr | (~rst & init_wr);
    assign mem_wr_adr_2 = run_wr ? wb_adr  : init_adr_q;
    assign mem_wr_din_2 = run_wr ? wb_data : '0;
    assign sat_pulse    = run_wr & wb_sat;

endmodule
